// File: rtl/maxpool_2x2_stream.sv
// 2x2 / stride-2 max-pooling stage for a raster pixel stream (valid/sop/eop framing).
// A one-row line buffer keeps the horizontal pair maxima of each even input row.
module maxpool_2x2_stream #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 26,
    parameter int IMG_HEIGHT  = 26,
    parameter int SIGNED_DATA = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_sop,
    input  logic                  i_eop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic                  o_frame_err,
    output logic                  busy
);
    localparam int OUT_W = IMG_WIDTH / 2;
    localparam int OUT_H = IMG_HEIGHT / 2;
    localparam int CW    = $clog2(IMG_WIDTH);
    localparam int RW    = $clog2(IMG_HEIGHT);
    localparam int IW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [CW-1:0] LAST_COL  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] LAST_OCOL = CW'(2 * OUT_W - 1);
    localparam logic [RW-1:0] LAST_OROW = RW'(2 * OUT_H - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  done;      // last pixel of the frame already processed
    logic                  eop_sent;  // o_eop already emitted for the current frame
    logic [DATA_WIDTH-1:0] pair_reg;
    logic [DATA_WIDTH-1:0] linebuf [OUT_W];

    logic                  beat, start, proc, ends, emit, lb_wr;
    logic                  at_last, last_out, in_win, frame_err;
    logic [CW-1:0]         pc;
    logic [RW-1:0]         pr;
    logic [IW-1:0]         lb_idx;
    logic [DATA_WIDTH-1:0] h_max, pooled;

    function automatic logic [DATA_WIDTH-1:0] pick_max(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
        logic a_gt;
        if (SIGNED_DATA != 0) a_gt = $signed(a) > $signed(b);
        else                  a_gt = a > b;
        return a_gt ? a : b;
    endfunction

    // A sop beat is always taken as pixel (0,0), whatever the counters hold.
    always_comb begin
        beat      = clk_en & i_valid;
        start     = beat & i_sop;
        proc      = start | (beat & (state == ACTIVE) & ~done);
        pc        = start ? '0 : col;
        pr        = start ? '0 : row;
        at_last   = (pc == LAST_COL) && (pr == LAST_ROW);
        last_out  = (pc == LAST_OCOL) && (pr == LAST_OROW);
        in_win    = (pc <= LAST_OCOL) && (pr <= LAST_OROW);
        lb_idx    = IW'(pc >> 1);
        h_max     = pick_max(pair_reg, i_data);
        pooled    = pick_max(linebuf[lb_idx], h_max);
        emit      = proc & pc[0] & pr[0] & in_win;
        lb_wr     = proc & pc[0] & ~pr[0] & in_win;
        ends      = beat & i_eop & ((state == ACTIVE) | start);
        frame_err = (start & (state == ACTIVE) & ~eop_sent) | (ends & ~at_last);
    end

    always_ff @(posedge clk) begin
        if (lb_wr) linebuf[lb_idx] <= h_max;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            done        <= 1'b0;
            eop_sent    <= 1'b0;
            pair_reg    <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_sop       <= 1'b0;
            o_eop       <= 1'b0;
            o_frame_err <= 1'b0;
        end else if (clk_en) begin
            o_valid     <= emit;
            o_sop       <= emit & (pr == RW'(1)) & (pc == CW'(1));
            o_eop       <= emit & last_out;
            o_frame_err <= frame_err;
            if (emit) o_data <= pooled;
            if (proc && !pc[0]) pair_reg <= i_data;

            // Counters park on the last pixel so trailing beats stay ignored.
            if (proc) begin
                if (at_last) begin
                    col  <= pc;
                    row  <= pr;
                    done <= 1'b1;
                end else if (pc == LAST_COL) begin
                    col  <= '0;
                    row  <= pr + 1'b1;
                    done <= 1'b0;
                end else begin
                    col  <= pc + 1'b1;
                    row  <= pr;
                    done <= 1'b0;
                end
            end

            if (emit && last_out) eop_sent <= 1'b1;
            else if (start)       eop_sent <= 1'b0;

            if (ends)       state <= IDLE;
            else if (start) state <= ACTIVE;
        end
    end

    assign busy = (state == ACTIVE);
endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Directed bench for maxpool_2x2_stream: five instances with different geometry/signedness
// share one input stream; each scenario task checks the instance it targets.
module tb_maxpool_2x2_stream;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_sop = 1'b0;
    logic       i_eop = 1'b0;
    logic [7:0] i_data = 8'h00;

    logic [7:0] d4, d5, d2s, d2u, d26;
    logic v4, s4, e4, fe4, b4;
    logic v5, s5, e5, fe5, b5;
    logic v2s, s2s, e2s, fe2s, b2s;
    logic v2u, s2u, e2u, fe2u, b2u;
    logic v26, s26, e26, fe26, b26;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    maxpool_2x2_stream #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .SIGNED_DATA(0)) u4 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_data(i_data), .i_valid(i_valid),
        .i_sop(i_sop), .i_eop(i_eop), .o_data(d4), .o_valid(v4), .o_sop(s4), .o_eop(e4),
        .o_frame_err(fe4), .busy(b4));
    maxpool_2x2_stream #(.DATA_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(5), .SIGNED_DATA(0)) u5 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_data(i_data), .i_valid(i_valid),
        .i_sop(i_sop), .i_eop(i_eop), .o_data(d5), .o_valid(v5), .o_sop(s5), .o_eop(e5),
        .o_frame_err(fe5), .busy(b5));
    maxpool_2x2_stream #(.DATA_WIDTH(8), .IMG_WIDTH(2), .IMG_HEIGHT(2), .SIGNED_DATA(1)) u2s (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_data(i_data), .i_valid(i_valid),
        .i_sop(i_sop), .i_eop(i_eop), .o_data(d2s), .o_valid(v2s), .o_sop(s2s), .o_eop(e2s),
        .o_frame_err(fe2s), .busy(b2s));
    maxpool_2x2_stream #(.DATA_WIDTH(8), .IMG_WIDTH(2), .IMG_HEIGHT(2), .SIGNED_DATA(0)) u2u (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_data(i_data), .i_valid(i_valid),
        .i_sop(i_sop), .i_eop(i_eop), .o_data(d2u), .o_valid(v2u), .o_sop(s2u), .o_eop(e2u),
        .o_frame_err(fe2u), .busy(b2u));
    maxpool_2x2_stream #(.DATA_WIDTH(8), .IMG_WIDTH(26), .IMG_HEIGHT(26), .SIGNED_DATA(0)) u26 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_data(i_data), .i_valid(i_valid),
        .i_sop(i_sop), .i_eop(i_eop), .o_data(d26), .o_valid(v26), .o_sop(s26), .o_eop(e26),
        .o_frame_err(fe26), .busy(b26));

    // Drive one cycle of inputs, then return 1 time unit after the edge that consumed them.
    task automatic beat(input logic [7:0] d, input logic s, input logic e,
                        input logic v, input logic en);
        i_data = d; i_sop = s; i_eop = e; i_valid = v; clk_en = en;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] umax(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // Full 0..15 frame into the 4x4 instance; pooled outputs must be 5,7,13,15.
    task automatic run_frame4(input bit err_first, input bit with_eop, input string tag);
        bit exp_v;
        for (int p = 0; p < 16; p++) begin
            beat(8'(p), p == 0, with_eop && (p == 15), 1'b1, 1'b1);
            exp_v = (p == 5) || (p == 7) || (p == 13) || (p == 15);
            checks++;
            if (v4 !== exp_v) begin
                errors++;
                $display("FAIL %s valid p=%0d: got %b expected %b", tag, p, v4, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (d4 !== 8'(p) || s4 !== (p == 5) || e4 !== (p == 15)) begin
                    errors++;
                    $display("FAIL %s out p=%0d: got d=%0d sop=%b eop=%b expected d=%0d sop=%b eop=%b",
                             tag, p, d4, s4, e4, p, p == 5, p == 15);
                end
            end
            checks++;
            if (fe4 !== (err_first && p == 0)) begin
                errors++;
                $display("FAIL %s frame_err p=%0d: got %b expected %b", tag, p, fe4, err_first && p == 0);
            end
        end
        checks++;
        if (b4 !== !with_eop) begin
            errors++;
            $display("FAIL %s busy: got %b expected %b", tag, b4, !with_eop);
        end
        beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (v4 !== 1'b0) begin
            errors++;
            $display("FAIL %s valid_clear: got %b expected 0", tag, v4);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_en = 1'b1; i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({v4, s4, e4, fe4, b4} !== 5'b0 || d4 !== 8'h00) begin
            errors++;
            $display("FAIL reset_u4: got v/s/e/err/busy=%b d=%0d expected 00000 d=0", {v4, s4, e4, fe4, b4}, d4);
        end
        checks++;
        if ({v26, b26, fe26} !== 3'b0 || d26 !== 8'h00) begin
            errors++;
            $display("FAIL reset_u26: got v/busy/err=%b d=%0d expected 000 d=0", {v26, b26, fe26}, d26);
        end
        rst_n = 1'b1;
        beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_pool_4x4();
        run_frame4(1'b0, 1'b1, "pool4");
    endtask

    task automatic test_odd_5x5();
        bit exp_v;
        logic [7:0] exp_d;
        for (int p = 0; p < 25; p++) begin
            beat(8'(p), p == 0, p == 24, 1'b1, 1'b1);
            exp_v = (p == 6) || (p == 8) || (p == 16) || (p == 18);
            exp_d = 8'(p);
            checks++;
            if (v5 !== exp_v) begin
                errors++;
                $display("FAIL odd5 valid p=%0d: got %b expected %b", p, v5, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (d5 !== exp_d || s5 !== (p == 6) || e5 !== (p == 18)) begin
                    errors++;
                    $display("FAIL odd5 out p=%0d: got d=%0d sop=%b eop=%b expected d=%0d sop=%b eop=%b",
                             p, d5, s5, e5, exp_d, p == 6, p == 18);
                end
            end
        end
        checks++;
        if (fe5 !== 1'b0 || b5 !== 1'b0) begin
            errors++;
            $display("FAIL odd5 end: got err=%b busy=%b expected err=0 busy=0", fe5, b5);
        end
        beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_signed();
        logic [7:0] fa[4];
        logic [7:0] fb[4];
        fa = '{8'hFD, 8'hFF, 8'hF8, 8'hFE};
        fb = '{8'h01, 8'hF8, 8'h02, 8'h03};
        for (int p = 0; p < 4; p++) beat(fa[p], p == 0, p == 3, 1'b1, 1'b1);
        checks++;
        if ({v2s, s2s, e2s, fe2s} !== 4'b1110 || d2s !== 8'hFF) begin
            errors++;
            $display("FAIL signed_a: got v/s/e/err=%b d=%h expected 1110 d=ff", {v2s, s2s, e2s, fe2s}, d2s);
        end
        checks++;
        if ({v2u, s2u, e2u} !== 3'b111 || d2u !== 8'hFF) begin
            errors++;
            $display("FAIL unsigned_a: got v/s/e=%b d=%h expected 111 d=ff", {v2u, s2u, e2u}, d2u);
        end
        for (int p = 0; p < 4; p++) beat(fb[p], p == 0, p == 3, 1'b1, 1'b1);
        checks++;
        if ({v2s, s2s, e2s, fe2s} !== 4'b1110 || d2s !== 8'h03) begin
            errors++;
            $display("FAIL signed_b: got v/s/e/err=%b d=%h expected 1110 d=03", {v2s, s2s, e2s, fe2s}, d2s);
        end
        checks++;
        if ({v2u, s2u, e2u, fe2u} !== 4'b1110 || d2u !== 8'hF8) begin
            errors++;
            $display("FAIL unsigned_b: got v/s/e/err=%b d=%h expected 1110 d=f8", {v2u, s2u, e2u, fe2u}, d2u);
        end
        beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_frame_err();
        for (int p = 0; p < 10; p++) beat(8'(p), p == 0, p == 9, 1'b1, 1'b1);
        checks++;
        if (fe4 !== 1'b1 || b4 !== 1'b0) begin
            errors++;
            $display("FAIL early_eop: got err=%b busy=%b expected err=1 busy=0", fe4, b4);
        end
        beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (fe4 !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: got %b expected 0", fe4);
        end
        run_frame4(1'b0, 1'b1, "after_err");
    endtask

    task automatic test_sop_restart();
        for (int p = 0; p < 6; p++) beat(8'(p), p == 0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (b4 !== 1'b1 || fe4 !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame: got busy=%b err=%b expected busy=1 err=0", b4, fe4);
        end
        run_frame4(1'b1, 1'b1, "restart");
    endtask

    task automatic test_back_to_back();
        run_frame4(1'b0, 1'b0, "no_eop");
        beat(8'd99, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (v4 !== 1'b0 || b4 !== 1'b1 || fe4 !== 1'b0) begin
            errors++;
            $display("FAIL extra_beat: got v=%b busy=%b err=%b expected v=0 busy=1 err=0", v4, b4, fe4);
        end
        run_frame4(1'b0, 1'b1, "b2b");
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 7; p++) beat(8'(p), p == 0, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({v4, s4, e4, fe4, b4} !== 5'b0 || d4 !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got v/s/e/err/busy=%b d=%0d expected 00000 d=0", {v4, s4, e4, fe4, b4}, d4);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int p = 7; p < 16; p++) begin
            beat(8'(p), 1'b0, p == 15, 1'b1, 1'b1);
            checks++;
            if (v4 !== 1'b0 || b4 !== 1'b0 || fe4 !== 1'b0) begin
                errors++;
                $display("FAIL no_sop p=%0d: got v=%b busy=%b err=%b expected 0 0 0", p, v4, b4, fe4);
            end
        end
        run_frame4(1'b0, 1'b1, "after_rst");
    endtask

    task automatic test_stream_26();
        logic [7:0] pix[676];
        logic [7:0] exp_d;
        logic       prev_v, prev_sop_exp;
        logic [7:0] prev_d;
        bit         drv_done;
        int         n_out;
        for (int k = 0; k < 676; k++) pix[k] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 13; i++)
            for (int j = 0; j < 13; j++)
                exp_q.push_back(umax(umax(pix[(2*i)*26 + 2*j], pix[(2*i)*26 + 2*j + 1]),
                                     umax(pix[(2*i+1)*26 + 2*j], pix[(2*i+1)*26 + 2*j + 1])));
        drv_done = 1'b0;
        n_out = 0;
        prev_v = v26;
        prev_d = d26;
        fork
            begin
                for (int k = 0; k < 676; k++) begin
                    logic en, v;
                    do begin
                        en = ($urandom_range(0, 3) != 0);
                        v  = ($urandom_range(0, 2) != 0);
                        beat(pix[k], k == 0, k == 675, v, en);
                    end while (!(en && v));
                end
                i_valid = 1'b0;
                drv_done = 1'b1;
            end
            begin
                int cyc = 0;
                logic en_s;
                while (!(drv_done && exp_q.size() == 0) && cyc < 20000) begin
                    @(posedge clk);
                    en_s = clk_en;
                    #1;
                    cyc++;
                    if (!en_s) begin
                        checks++;
                        if (v26 !== prev_v || d26 !== prev_d) begin
                            errors++;
                            $display("FAIL hold cyc=%0d: got v=%b d=%h expected v=%b d=%h", cyc, v26, d26, prev_v, prev_d);
                        end
                    end else if (v26 === 1'b1) begin
                        checks++;
                        prev_sop_exp = (n_out == 0);
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL stream extra output: got d=%h expected none", d26);
                        end else begin
                            exp_d = exp_q.pop_front();
                            if (d26 !== exp_d || s26 !== prev_sop_exp || e26 !== (n_out == 168)) begin
                                errors++;
                                $display("FAIL stream out %0d: got d=%h sop=%b eop=%b expected d=%h sop=%b eop=%b",
                                         n_out, d26, s26, e26, exp_d, prev_sop_exp, n_out == 168);
                            end
                        end
                        n_out++;
                    end
                    prev_v = v26;
                    prev_d = d26;
                end
            end
        join
        checks++;
        if (n_out != 169 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream count: got %0d outputs expected 169", n_out);
            exp_q.delete();
        end
        beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pool_4x4();
        test_odd_5x5();
        test_signed();
        test_frame_err();
        test_sop_restart();
        test_back_to_back();
        test_reset_mid();
        test_stream_26();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
